// File: rtl/exc_carrier_stage_if.sv
// Bundle of the stage-boundary signals between the upstream pipeline and the exception carrier stage.
// master drives instructions and control into the stage; slave is the stage itself.
interface exc_carrier_stage_if #(
  parameter int PC_W    = 32,
  parameter int NUM_SRC = 4,
  parameter int CODE_W  = 5,
  parameter int CNT_W   = 8
);
  logic               flush;
  logic               stall;
  logic               in_valid;
  logic [PC_W-1:0]    in_pc;
  logic               in_bd;
  logic               in_exc_valid;
  logic [CODE_W-1:0]  in_exc_code;
  logic [NUM_SRC-1:0] src_err;
  logic               exc_ack;
  logic               out_valid;
  logic [PC_W-1:0]    out_pc;
  logic               out_bd;
  logic               out_exc_valid;
  logic [CODE_W-1:0]  out_exc_code;
  logic               exc_pending;
  logic [CNT_W-1:0]   exc_count;

  modport master (
    output flush, stall, in_valid, in_pc, in_bd, in_exc_valid, in_exc_code, src_err, exc_ack,
    input  out_valid, out_pc, out_bd, out_exc_valid, out_exc_code, exc_pending, exc_count
  );

  modport slave (
    input  flush, stall, in_valid, in_pc, in_bd, in_exc_valid, in_exc_code, src_err, exc_ack,
    output out_valid, out_pc, out_bd, out_exc_valid, out_exc_code, exc_pending, exc_count
  );
endinterface

// File: rtl/exc_carrier_stage.sv
// Pipeline register carrying PC, delay-slot flag and exception cause between stages; merges local
// exception sources, squashes younger slots while an exception is pending, counts exceptions.
module exc_carrier_stage #(
  parameter int                        PC_W      = 32,
  parameter int                        NUM_SRC   = 4,
  parameter int                        CODE_W    = 5,
  parameter logic [NUM_SRC*CODE_W-1:0] EXC_CODES = {5'd4, 5'd5, 5'd10, 5'd12},
  parameter int                        CNT_W     = 8
) (
  input  logic               clk,
  input  logic               reset,
  exc_carrier_stage_if.slave bus
);

  logic              r_valid;
  logic [PC_W-1:0]   r_pc;
  logic              r_bd;
  logic              r_exc_valid;
  logic [CODE_W-1:0] r_exc_code;
  logic              r_pending;
  logic [CNT_W-1:0]  r_count;

  logic              w_load;
  logic              w_live;
  logic              w_exc;
  logic              w_set;
  logic [CODE_W-1:0] w_src_code;
  logic [CODE_W-1:0] w_code;

  // Scan from the top down so the lowest-index set source is the one that sticks.
  always_comb begin
    w_src_code = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (bus.src_err[i]) w_src_code = EXC_CODES[i*CODE_W +: CODE_W];
    end
  end

  always_comb begin
    w_load = ~bus.flush & ~bus.stall;
    w_live = bus.in_valid & ~r_pending;
    w_exc  = bus.in_exc_valid | (|bus.src_err);
    w_set  = w_load & w_live & w_exc;
    w_code = '0;
    if (bus.in_exc_valid)  w_code = bus.in_exc_code;
    else if (|bus.src_err) w_code = w_src_code;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid     <= 1'b0;
      r_pc        <= '0;
      r_bd        <= 1'b0;
      r_exc_valid <= 1'b0;
      r_exc_code  <= '0;
    end else if (bus.flush) begin
      r_valid     <= 1'b0;
      r_pc        <= '0;
      r_bd        <= 1'b0;
      r_exc_valid <= 1'b0;
      r_exc_code  <= '0;
    end else if (!bus.stall) begin
      if (w_live) begin
        r_valid     <= 1'b1;
        r_pc        <= bus.in_pc;
        r_bd        <= bus.in_bd;
        r_exc_valid <= w_exc;
        r_exc_code  <= w_code;
      end else begin
        r_valid     <= 1'b0;
        r_pc        <= '0;
        r_bd        <= 1'b0;
        r_exc_valid <= 1'b0;
        r_exc_code  <= '0;
      end
    end
  end

  // A new exception outranks an acknowledge arriving on the same edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pending <= 1'b0;
    end else if (w_set) begin
      r_pending <= 1'b1;
    end else if (bus.exc_ack) begin
      r_pending <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (w_set && (r_count != {CNT_W{1'b1}})) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign bus.out_valid     = r_valid;
  assign bus.out_pc        = r_pc;
  assign bus.out_bd        = r_bd;
  assign bus.out_exc_valid = r_exc_valid;
  assign bus.out_exc_code  = r_exc_code;
  assign bus.exc_pending   = r_pending;
  assign bus.exc_count     = r_count;

endmodule
